alu_wide_seq: RTL and testbench

//  Byte-serial sequencer that drives the 8-bit alu (a, b, op, xy, cin -> q, cout)
//  to perform BYTES*8-bit operations, chaining carry between bytes. Sits between
//  the control unit and the alu; one alu pass per clock, one byte per pass.

---
 rtl/alu_wide_seq.sv | 92 +++++++++
 tb/tb_alu_wide_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: byte-serial sequencer running an external 8-bit alu for BYTES*8-bit ops
// in:  clk, rst (async, active high), start, op[3:0], xy, cin, a/b[W-1:0], alu_q[7:0], alu_cout
// out: busy, done (1-cycle pulse), q[W-1:0], cout, alu_a/alu_b[7:0], alu_op[3:0], alu_xy, alu_cin
module alu_wide_seq #(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic                 xy,
  input  logic                 cin,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [8*BYTES-1:0]   q,
  output logic                 cout,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_op,
  output logic                 alu_xy,
  output logic                 alu_cin,
  input  logic [7:0]           alu_q,
  input  logic                 alu_cout
);
  localparam int W = 8*BYTES;
  localparam int CW = $clog2(BYTES+1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, idx;
  logic [W-1:0] a_r, b_r, shadow, shadow_nxt;
  logic [3:0] op_r, chain_op;
  logic xy_r, cin_r, carry, msb_first, last, accept;
  always_comb begin
    // right shifts must walk from the top byte down so carry flows towards the LSB
    msb_first = op_r[3:2] == 2'b11 && xy_r;
    idx = msb_first ? CW'(BYTES-1) - cnt : cnt;
    // opcode used on every pass after the first: the carry-consuming variant
    chain_op = op_r[3:2] == 2'b11 ? (xy_r ? 4'hd : 4'h9) :
               op_r[3]            ? (xy_r ? 4'h8 : 4'h9) :
               op_r[2]            ? (op_r | 4'h1)        : op_r;
    last = cnt == CW'(BYTES-1);
    accept = start && state == IDLE;
    state_nxt = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    busy = state == RUN;
    alu_a = busy ? a_r[idx*8 +: 8] : 8'h00;
    alu_b = busy ? b_r[idx*8 +: 8] : 8'h00;
    alu_op = !busy ? 4'h0 : cnt == '0 ? op_r : chain_op;
    alu_xy = busy && xy_r;
    alu_cin = busy && (cnt == '0 ? cin_r : carry);
    shadow_nxt = shadow;
    shadow_nxt[idx*8 +: 8] = alu_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
      xy_r <= 1'b0;
      cin_r <= 1'b0;
      carry <= 1'b0;
      shadow <= '0;
      q <= '0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= busy && last;
      if (accept) begin
        a_r <= a;
        b_r <= b;
        op_r <= op;
        xy_r <= xy;
        cin_r <= cin;
        cnt <= '0;
      end else if (busy) begin
        cnt <= last ? '0 : cnt + 1'b1;
        carry <= alu_cout;
        shadow <= shadow_nxt;
        if (last) begin
          q <= shadow_nxt;
          cout <= alu_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: scoreboard bench for alu_wide_seq with a behavioural 8-bit alu
module tb_alu_wide_seq;
  localparam int BYTES = 2;
  localparam int W = 16;
  typedef struct packed { logic [W-1:0] q; logic c; } exp_t;
  logic clk = 0, rst = 1, start = 0, xy = 0, cin = 0;
  logic [3:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic busy, done, cout, alu_xy, alu_cin, alu_cout;
  logic [W-1:0] q;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_q;
  logic [8:0] alu_r;
  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0, lat;
  logic [W-1:0] last_q = 0;
  logic [3:0] p_op[2];
  logic p_cin[2];
  logic [7:0] p_a[2];
  always #5 clk = ~clk;
  alu_wide_seq #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .xy(xy), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .cout(cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_xy(alu_xy), .alu_cin(alu_cin),
    .alu_q(alu_q), .alu_cout(alu_cout)
  );
  always_comb begin
    case (alu_op)
      4'h0: alu_r = {1'b0, alu_a & alu_b};
      4'h1: alu_r = {1'b0, alu_a | alu_b};
      4'h2: alu_r = {1'b0, alu_a ^ alu_b};
      4'h3: alu_r = {1'b0, ~alu_a};
      4'h4: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      4'h5: alu_r = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      4'h6: alu_r = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      4'h7: alu_r = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'(alu_cin);
      4'h8: alu_r = alu_xy ? {alu_cin, alu_a} : {alu_a, 1'b0};
      4'h9: alu_r = {alu_a, alu_cin};
      4'hc: alu_r = alu_xy ? {alu_a[0], 1'b0, alu_a[7:1]} : {alu_a, 1'b0};
      4'hd: alu_r = {alu_a[0], alu_cin, alu_a[7:1]};
      default: alu_r = {alu_cin, alu_a};
    endcase
    {alu_cout, alu_q} = alu_r;
  end
  function automatic logic [W:0] ref_w(input logic [3:0] o, input logic c, input logic [W-1:0] ra, rb);
    case (o)
      4'h0: return {1'b0, ra & rb};
      4'h1: return {1'b0, ra | rb};
      4'h2: return {1'b0, ra ^ rb};
      4'h3: return {1'b0, ~ra};
      4'h4: return {1'b0, ra} + {1'b0, rb};
      4'h5: return {1'b0, ra} + {1'b0, rb} + 17'(c);
      4'h6: return {1'b0, ra} + {1'b0, ~rb} + 17'd1;
      4'h7: return {1'b0, ra} + {1'b0, ~rb} + 17'(c);
      4'h8: return {ra, 1'b0};
      4'h9: return {ra, c};
      4'hc: return {ra[0], 1'b0, ra[W-1:1]};
      default: return {ra[0], c, ra[W-1:1]};
    endcase
  endfunction
  task automatic do_op(input logic [3:0] o, input logic x, c, input logic [W-1:0] ra, rb, eq, input logic ec);
    exp_t e;
    int np;
    @(negedge clk);
    op = o; xy = x; cin = c; a = ra; b = rb; start = 1;
    exp_q.push_back('{q: eq, c: ec});
    @(negedge clk);
    start = 0;
    lat = 1;
    np = 0;
    while (!done && lat < 20) begin
      if (busy && np < 2) begin
        p_op[np] = alu_op; p_cin[np] = alu_cin; p_a[np] = alu_a; np++;
      end
      if (busy) begin
        n_cmp++;
        if (q !== last_q) begin n_err++; $display("FAIL hold_q: q=%h required %h", q, last_q); end
      end
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL done_timeout: op=%h no done within %0d cycles", o, lat);
    end else begin
      if (q !== e.q) begin n_err++; $display("FAIL result_q op=%h xy=%b a=%h b=%h: q=%h required %h", o, x, ra, rb, q, e.q); end
      n_cmp++;
      if (cout !== e.c) begin n_err++; $display("FAIL result_cout op=%h a=%h b=%h: cout=%b required %b", o, ra, rb, cout, e.c); end
    end
    last_q = e.q;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, cout} !== 3'b000) begin n_err++; $display("FAIL reset_flags: busy,done,cout=%b required 000", {busy, done, cout}); end
    n_cmp++;
    if (q !== '0) begin n_err++; $display("FAIL reset_q: q=%h required 0000", q); end
    n_cmp++;
    if ({alu_a, alu_b, alu_op, alu_xy, alu_cin} !== '0) begin
      n_err++; $display("FAIL reset_alu: alu_a=%h alu_b=%h alu_op=%h xy=%b cin=%b required all 0", alu_a, alu_b, alu_op, alu_xy, alu_cin);
    end
    rst = 0;
  endtask
  task automatic test_add();
    do_op(4'h4, 0, 0, 16'h00FF, 16'h0001, 16'h0100, 0);
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL add_latency: %0d edges required 3", lat); end
    n_cmp++;
    if ({p_op[0], p_op[1], p_cin[1]} !== {4'h4, 4'h5, 1'b1}) begin
      n_err++; $display("FAIL add_chain: ops %h,%h cin1=%b required 4,5,1", p_op[0], p_op[1], p_cin[1]);
    end
  endtask
  task automatic test_sub();
    do_op(4'h6, 0, 0, 16'h0100, 16'h0001, 16'h00FF, 1);
    n_cmp++;
    if (p_op[1] !== 4'h7) begin n_err++; $display("FAIL sub_chain: pass1 op=%h required 7", p_op[1]); end
    do_op(4'h6, 0, 0, 16'h0000, 16'h0001, 16'hFFFF, 0);
  endtask
  task automatic test_shift_left();
    do_op(4'h8, 0, 0, 16'h8001, 16'h0000, 16'h0002, 1);
    n_cmp++;
    if ({p_a[0], p_op[1], p_cin[1]} !== {8'h01, 4'h9, 1'b0}) begin
      n_err++; $display("FAIL shl_chain: a0=%h op1=%h cin1=%b required 01,9,0", p_a[0], p_op[1], p_cin[1]);
    end
  endtask
  task automatic test_shift_right();
    do_op(4'hc, 1, 0, 16'h0102, 16'h0000, 16'h0081, 0);
    n_cmp++;
    if ({p_a[0], p_a[1], p_op[1], p_cin[1]} !== {8'h01, 8'h02, 4'hd, 1'b1}) begin
      n_err++; $display("FAIL shr_chain: a0=%h a1=%h op1=%h cin1=%b required 01,02,d,1", p_a[0], p_a[1], p_op[1], p_cin[1]);
    end
  endtask
  task automatic test_busy_ignore();
    int nd;
    exp_t e;
    @(negedge clk);
    op = 4'h4; xy = 0; cin = 0; a = 16'h0003; b = 16'h0004; start = 1;
    exp_q.push_back('{q: 16'h0007, c: 1'b0});
    @(negedge clk);
    a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    start = 0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          if ({q, cout} !== {e.q, e.c}) begin n_err++; $display("FAIL ignore_result: q=%h cout=%b required %h %b", q, cout, e.q, e.c); end
        end
      end
    end
    n_cmp++;
    if (nd !== 1) begin n_err++; $display("FAIL ignore_done_count: %0d dones required 1", nd); end
    exp_q.delete();
    last_q = 16'h0007;
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int n;
    do_op(4'h4, 0, 0, 16'h1234, 16'h1111, 16'h2345, 0);
    op = 4'h6; xy = 0; cin = 0; a = 16'h0005; b = 16'h0003; start = 1;
    exp_q.push_back('{q: 16'h0002, c: 1'b1});
    @(negedge clk);
    start = 0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL b2b_start: busy,done=%b required 10", {busy, done}); end
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    n_cmp++;
    if (!done || {q, cout} !== {e.q, e.c}) begin
      n_err++; $display("FAIL b2b_result: done=%b q=%h cout=%b required 1 %h %b", done, q, cout, e.q, e.c);
    end
    last_q = e.q;
  endtask
  task automatic test_reset_abort();
    int nd;
    @(negedge clk);
    op = 4'h4; a = 16'h0101; b = 16'h0101; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({busy, done, cout, q} !== '0) begin n_err++; $display("FAIL abort_outputs: busy=%b done=%b cout=%b q=%h required 0", busy, done, cout, q); end
    n_cmp++;
    if ({alu_a, alu_b, alu_op, alu_xy, alu_cin} !== '0) begin n_err++; $display("FAIL abort_alu: alu_a=%h alu_op=%h required 0", alu_a, alu_op); end
    @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (6) begin @(negedge clk); if (done || busy) nd++; end
    n_cmp++;
    if (nd !== 0) begin n_err++; $display("FAIL abort_no_done: %0d active cycles required 0", nd); end
    last_q = '0;
  endtask
  task automatic test_random();
    logic [3:0] o;
    logic x, c;
    logic [W-1:0] ra, rb;
    logic [W:0] r;
    int k;
    for (int i = 0; i < 5000; i++) begin
      k = $urandom_range(0, 11);
      case (k)
        8: o = 4'h8;
        9: o = 4'h9;
        10: o = 4'hc;
        11: o = 4'hd;
        default: o = 4'(k);
      endcase
      x = k < 8 ? 1'($urandom) : o[2];
      c = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      r = ref_w(o, c, ra, rb);
      do_op(o, x, c, ra, rb, r[W-1:0], r[W]);
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift_left();
    test_shift_right();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
